// File: rtl/int_sequencer.sv
// Interrupt initiator: edge-detects int_req, waits out control flow, drains the pipeline,
// sequences the three PC/CCR push steps, loads the vector and blocks nesting until RTI.
module int_sequencer #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        stall,
  input  logic        branch_pending,
  input  logic        rti_done,
  output logic        int_active,
  output logic [1:0]  int_counter,
  output logic        fetch_freeze,
  output logic        inject_nop,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        in_service
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StDrain,
    StPush,
    StVector,
    StService
  } state_e;

  localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       int_req_q;
  logic       armed_q;
  logic       req_edge;

  // The first sample after reset only primes the history, so a level held through reset is
  // not mistaken for a new request.
  assign req_edge  = armed_q & int_req & ~int_req_q;
  assign pc_target = VECTOR_ADDR;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      pending_q <= 1'b0;
      int_req_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      int_req_q <= int_req;
      armed_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (req_edge || pending_q) state_d = StWait;
      end
      StWait: begin
        if (!stall && !branch_pending) begin
          state_d   = StDrain;
          cnt_d     = DrainLoad;
          pending_d = 1'b0;
        end
      end
      StDrain: begin
        // cnt_q is already 0 on exit, which is the first push step.
        if (cnt_q == 3'd0) state_d = StPush;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StPush: begin
        if (cnt_q == 3'd2) begin
          state_d = StVector;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StVector: begin
        state_d = StService;
      end
      StService: begin
        if (rti_done) state_d = (pending_q || req_edge) ? StWait : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // A fresh edge wins over the clear on leaving WAIT: it is a new, distinct request.
    if (req_edge) pending_d = 1'b1;
  end

  always_comb begin
    int_active   = 1'b0;
    int_counter  = 2'd0;
    fetch_freeze = 1'b0;
    inject_nop   = 1'b0;
    pc_load      = 1'b0;
    in_service   = 1'b0;
    unique case (state_q)
      StDrain: begin
        fetch_freeze = 1'b1;
        inject_nop   = 1'b1;
      end
      StPush: begin
        fetch_freeze = 1'b1;
        inject_nop   = 1'b1;
        int_active   = 1'b1;
        int_counter  = cnt_q[1:0];
      end
      StVector: begin
        pc_load = 1'b1;
      end
      StService: begin
        in_service = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed vector table, hand-written corner sequences and random
// stimulus checked against a cycle-position reference model.
module tb_int_sequencer;

  localparam int          D   = 3;
  localparam logic [31:0] VEC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        int_req;
  logic        stall;
  logic        branch_pending;
  logic        rti_done;
  logic        int_active;
  logic [1:0]  int_counter;
  logic        fetch_freeze;
  logic        inject_nop;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        in_service;

  int_sequencer #(
    .VECTOR_ADDR  (VEC),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .int_req        (int_req),
    .stall          (stall),
    .branch_pending (branch_pending),
    .rti_done       (rti_done),
    .int_active     (int_active),
    .int_counter    (int_counter),
    .fetch_freeze   (fetch_freeze),
    .inject_nop     (inject_nop),
    .pc_load        (pc_load),
    .pc_target      (pc_target),
    .in_service     (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Snapshot: {int_active, int_counter[1:0], fetch_freeze, inject_nop, pc_load, in_service}
  logic [6:0]  out_s;
  logic [31:0] pc_s;

  // Reference model: mode 0 idle, 1 waiting, 2 in sequence (m_pos cycles since drain start),
  // 3 servicing.
  int m_mode = 0;
  int m_pos  = 0;
  bit m_pend = 0;
  bit m_prev = 0;
  bit m_armed = 0;

  function automatic logic [6:0] m_out();
    logic [6:0] o;
    int k;
    o = '0;
    if (m_mode == 2) begin
      if (m_pos >= D && m_pos < D + 3) begin
        k      = m_pos - D;
        o[6]   = 1'b1;
        o[5:4] = 2'(k);
      end
      if (m_pos < D + 3) begin
        o[3] = 1'b1;
        o[2] = 1'b1;
      end
      if (m_pos == D + 3) o[1] = 1'b1;
    end else if (m_mode == 3) begin
      o[0] = 1'b1;
    end
    return o;
  endfunction

  function automatic void m_step(bit rn, bit rq, bit st, bit bp, bit rt);
    bit e;
    if (!rn) begin
      m_mode = 0; m_pos = 0; m_pend = 0; m_prev = 0; m_armed = 0;
      return;
    end
    e       = rq && !m_prev && m_armed;
    m_prev  = rq;
    m_armed = 1;
    case (m_mode)
      0: if (e || m_pend) m_mode = 1;
      1: if (!st && !bp) begin m_mode = 2; m_pos = 0; m_pend = 0; end
      2: begin m_pos++; if (m_pos > D + 3) m_mode = 3; end
      3: if (rt) m_mode = (m_pend || e) ? 1 : 0;
      default: m_mode = 0;
    endcase
    if (e) m_pend = 1;
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    n_checks++;
    if ({pc_s, out_s} !== {VEC, exp}) begin
      n_err++;
      $display("FAIL %s cycle %0d: got pc=%h out=%b, expected pc=%h out=%b",
               name, cyc, pc_s, out_s, VEC, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic sample(input bit chk);
    @(negedge clk);
    cyc++;
    out_s = {int_active, int_counter, fetch_freeze, inject_nop, pc_load, in_service};
    pc_s  = pc_target;
    if (chk) check("model", m_out());
  endtask

  task automatic drive(input bit rn, input bit rq, input bit st, input bit bp, input bit rt);
    reset          = rn;
    int_req        = rq;
    stall          = st;
    branch_pending = bp;
    rti_done       = rt;
    m_step(rn, rq, st, bp, rt);
  endtask

  task automatic tick(input bit rn, input bit rq, input bit st, input bit bp, input bit rt);
    sample(1'b1);
    drive(rn, rq, st, bp, rt);
  endtask

  typedef struct {
    bit         rn, rq, st, bp, rt;
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_DRN  = 7'b0001100;
  localparam logic [6:0] O_P0   = 7'b1001100;
  localparam logic [6:0] O_P1   = 7'b1011100;
  localparam logic [6:0] O_P2   = 7'b1101100;
  localparam logic [6:0] O_VEC  = 7'b0000010;
  localparam logic [6:0] O_SVC  = 7'b0000001;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acts, loads, frz, found;
    bit rq_r;

    reset = 1'b0; int_req = 1'b0; stall = 1'b0; branch_pending = 1'b0; rti_done = 1'b0;

    // Basic take (edge in cycle 2), then rti, ignored rti in IDLE, stall/branch blocking.
    tbl.push_back('{1, 0, 0, 0, 0, O_NONE});  // 0
    tbl.push_back('{1, 0, 0, 0, 0, O_NONE});  // 1
    tbl.push_back('{1, 1, 0, 0, 0, O_NONE});  // 2 edge
    tbl.push_back('{1, 1, 0, 0, 0, O_NONE});  // 3 wait
    tbl.push_back('{1, 1, 0, 0, 0, O_DRN});   // 4
    tbl.push_back('{1, 1, 0, 0, 0, O_DRN});   // 5
    tbl.push_back('{1, 1, 0, 0, 0, O_DRN});   // 6
    tbl.push_back('{1, 1, 0, 0, 0, O_P0});    // 7
    tbl.push_back('{1, 1, 0, 0, 0, O_P1});    // 8
    tbl.push_back('{1, 1, 0, 0, 0, O_P2});    // 9
    tbl.push_back('{1, 1, 0, 0, 0, O_VEC});   // 10
    tbl.push_back('{1, 1, 0, 0, 0, O_SVC});   // 11
    tbl.push_back('{1, 1, 0, 0, 1, O_SVC});   // 12 rti
    tbl.push_back('{1, 1, 0, 0, 0, O_NONE});  // 13 level held, no edge
    tbl.push_back('{1, 0, 0, 0, 0, O_NONE});  // 14
    tbl.push_back('{1, 0, 0, 0, 1, O_NONE});  // 15 rti outside service
    tbl.push_back('{1, 1, 1, 0, 0, O_NONE});  // 16 edge under stall
    tbl.push_back('{1, 1, 1, 0, 0, O_NONE});  // 17
    tbl.push_back('{1, 1, 1, 0, 0, O_NONE});  // 18
    tbl.push_back('{1, 1, 0, 1, 0, O_NONE});  // 19 branch
    tbl.push_back('{1, 1, 0, 0, 0, O_NONE});  // 20 clear
    tbl.push_back('{1, 1, 0, 0, 0, O_DRN});   // 21
    tbl.push_back('{1, 1, 0, 0, 0, O_DRN});   // 22
    tbl.push_back('{1, 1, 0, 0, 0, O_DRN});   // 23
    tbl.push_back('{1, 1, 0, 0, 0, O_P0});    // 24
    tbl.push_back('{1, 1, 0, 0, 0, O_P1});    // 25
    tbl.push_back('{1, 1, 0, 0, 0, O_P2});    // 26
    tbl.push_back('{1, 1, 0, 0, 0, O_VEC});   // 27
    tbl.push_back('{1, 1, 0, 0, 0, O_SVC});   // 28

    sample(1'b0); drive(0, 0, 0, 0, 0);
    sample(1'b0); drive(0, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      sample(1'b0);
      check($sformatf("table[%0d]", i), tbl[i].exp);
      drive(tbl[i].rn, tbl[i].rq, tbl[i].st, tbl[i].bp, tbl[i].rt);
    end

    // Nesting: edge during SERVICE is held, rti then re-enters the full sequence.
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    acts = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0, 0, 0);
      acts += int'(out_s[6]);
    end
    check_cnt("nest_no_push", acts, 0);
    tick(1, 1, 0, 0, 1);
    acts = 0; loads = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1, 1, 0, 0, 0);
      acts  += int'(out_s[6]);
      loads += int'(out_s[1]);
    end
    check_cnt("nest_resequence_pushes", acts, 3);
    check_cnt("nest_resequence_loads", loads, 1);

    // Coincident rti and edge -> WAIT; stall held in WAIT blocks DRAIN.
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 1);
    frz = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 1, 0, 0);
      frz += int'(out_s[3]);
    end
    check("coincident_wait", O_NONE);
    check_cnt("stall_blocks_drain", frz, 0);
    loads = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 0, 0, 0);
      loads += int'(out_s[1]);
    end
    check_cnt("coincident_sequence", loads, 1);

    // Level hold: one sequence per edge however long int_req stays high.
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    acts = 0; loads = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1, 1, 0, 0, 0);
      acts  += int'(out_s[6]);
      loads += int'(out_s[1]);
    end
    check_cnt("level_pushes", acts, 3);
    check_cnt("level_loads", loads, 1);
    tick(1, 1, 0, 0, 1);
    loads = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 0, 0, 0);
      loads += int'(out_s[1]);
    end
    check_cnt("level_no_retrigger", loads, 0);
    tick(1, 0, 0, 0, 0);
    loads = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1, 1, 0, 0, 0);
      loads += int'(out_s[1]);
    end
    check_cnt("level_second_edge", loads, 1);

    // Reset mid-PUSH at int_counter == 1, released with int_req still high.
    tick(1, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      sample(1'b1);
      if (out_s[6] && out_s[5:4] == 2'd1) begin
        found = 1;
        drive(0, 1, 0, 0, 0);
      end else begin
        drive(1, 1, 0, 0, 0);
      end
    end
    check_cnt("reach_push_step1", found, 1);
    sample(1'b1);
    check("reset_mid_push", O_NONE);
    drive(1, 1, 0, 0, 0);
    frz = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1, 1, 0, 0, 0);
      frz += int'(out_s != O_NONE);
    end
    check_cnt("no_request_after_reset", frz, 0);

    // Random stimulus against the model.
    rq_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq_r = ~rq_r;
      tick($urandom_range(0, 199) != 0, rq_r, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Initiator side of the processor's interrupt path: drives the interrupt signal and the 2-bit counter that the memory stage consumes to push PC and CCR onto the stack.
- Edge-detects an external request and waits until no control-flow instruction is in flight.
- Freezes fetch and drains the pipeline with NOPs, then sequences three push steps and loads the interrupt vector into the PC.
- Blocks further interrupts until the service routine's RTI retires.

Parameters:
- VECTOR_ADDR, 32'h0000_0000, PC value loaded when the interrupt is taken.
- DRAIN_CYCLES, 3, NOP-injection cycles before the first push; valid range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- int_req  in  1  external interrupt request, level input; rising edge detected internally.
- stall  in  1  HDU stall asserted this cycle.
- branch_pending  in  1  branch, jump, call or return in execute this cycle.
- rti_done  in  1  one-cycle pulse when RTI's CCR pop completes in write-back.
- int_active  out  1  interrupt-step strobe to the memory stage.
- int_counter  out  2  push step: 0 = PC[31:16], 1 = PC[15:0], 2 = CCR.
- fetch_freeze  out  1  hold the PC and the fetch/decode register.
- inject_nop  out  1  force the decode control-unit mux to NOP.
- pc_load  out  1  load pc_target into the PC this cycle.
- pc_target  out  32  constant VECTOR_ADDR.
- in_service  out  1  service routine executing.

Behaviour:
- Reset (reset = 0 at a clock edge):
  - State goes to IDLE; the pending flag and the edge-detect history register clear.
  - All outputs are 0 except pc_target, which is always VECTOR_ADDR.
  - A reset mid-sequence aborts immediately; no partial push continues.
- Edge detect: req_edge = int_req & ~int_req_q, with int_req_q registered every cycle. The pending flag sets on req_edge in any state, is one entry deep, and a second edge while already pending is dropped.
- State machine (one-hot or encoded, registered):
  - IDLE: if req_edge or pending, go to WAIT.
  - WAIT: all outputs 0. When stall = 0 and branch_pending = 0 in the same cycle, go to DRAIN, clear pending and load the drain counter with DRAIN_CYCLES-1.
  - DRAIN: fetch_freeze = 1, inject_nop = 1. The counter decrements each cycle; on 0, go to PUSH with int_counter = 0. Duration is exactly DRAIN_CYCLES cycles.
  - PUSH: fetch_freeze = 1, inject_nop = 1, int_active = 1, and int_counter steps 0, 1, 2 on consecutive cycles (exactly 3 cycles). After step 2, go to VECTOR. int_counter never shows 3.
  - VECTOR: pc_load = 1 and fetch_freeze = 0 for one cycle, then go to SERVICE.
  - SERVICE: in_service = 1. On rti_done, go to IDLE, or straight to WAIT if pending is set or req_edge is active that same cycle.
- Outputs are decoded from registered state, so an output changes one cycle after the edge that enters its state.
- Latency: a req_edge in cycle N, with no stall or branch, gives first DRAIN in cycle N+2, first int_active in cycle N+2+DRAIN_CYCLES, and pc_load 3 cycles after that.
- rti_done outside SERVICE is ignored.
- A stall or branch_pending after WAIT is ignored; fetch is frozen, so neither can originate new work.

Test Plan:
- Basic take, DRAIN_CYCLES = 3: raise int_req in cycle 10 -> DRAIN in cycles 12–14; int_active = 1 in cycles 15–17 with int_counter 0, 1, 2; pc_load = 1 with pc_target = 0 in cycle 18; in_service = 1 from cycle 19.
- Branch blocking: int_req edge while branch_pending = 1 for 4 cycles -> stays in WAIT with all outputs 0; DRAIN starts the cycle after branch_pending falls.
- Nesting: second int_req edge during SERVICE -> no new pushes; rti_done pulse -> returns to WAIT, then performs the full sequence again.
- Level hold: int_req held high for 50 cycles -> exactly one sequence (a single edge); a later low→high transition produces a second.
- Reset mid-PUSH: reset = 0 at int_counter = 1 -> next cycle all outputs 0 and state IDLE; releasing reset with int_req still high produces no request (history register clear, and the first sample after reset sets int_req_q).
- Coincident events: rti_done and req_edge in the same cycle -> goes to WAIT, not IDLE; stall held high in WAIT -> no DRAIN until stall = 0.
